ws2812_rx: RTL

Single-wire WS2812 stream decoder: the receive end of the WS2812 link driven by our transmitter. It samples an asynchronous WS2812 data line and measures each high pulse to decide 0/1. It assembles MSB-first 24-bit LED words, indexes them, and flags the end-of-frame latch gap. It is used for loopback verification of the encoder and as a pixel-sniffer front end.

---
 rtl/ws2812_pkg.sv | 16 +
 rtl/ws2812_sync.sv | 30 +++
 rtl/ws2812_rx.sv | 169 ++++++++++++++++
 3 files changed

// File: rtl/ws2812_pkg.sv
// WS2812 line timing shared by the transmitter and receiver, plus the receiver state encoding.
package ws2812_pkg;
  localparam int T0H_NS          = 350;
  localparam int T1H_NS          = 900;
  localparam int T_PERIOD_NS     = 1250;
  localparam int T_THRESH_NS     = 600;
  localparam int T_RESET_NS      = 50_000;
  localparam int T_RESET_LONG_NS = 280_000;

  typedef enum logic [1:0] {ST_SYNC, ST_IDLE, ST_HIGH, ST_LOW} rx_state_e;

  // Rounds up so a generated pulse is never shorter than its nominal width.
  function automatic int ns2cyc(input int ns, input int clk_mhz);
    return (ns * clk_mhz + 999) / 1000;
  endfunction
endpackage

// File: rtl/ws2812_sync.sv
// Two-flop synchronizer for the raw line, with edge strobes aligned to the synchronized level.
module ws2812_sync (
  input  logic clk,
  input  logic reset,
  input  logic d_i,
  output logic q_o,
  output logic rise_o,
  output logic fall_o
);
  logic s1_q, s2_q, rise_q, fall_q;

  // Edges come from the s1/s2 pair so each strobe is high in the same cycle q_o changes.
  always_ff @(posedge clk) begin
    if (reset) begin
      s1_q   <= 1'b0;
      s2_q   <= 1'b0;
      rise_q <= 1'b0;
      fall_q <= 1'b0;
    end else begin
      s1_q   <= d_i;
      s2_q   <= s1_q;
      rise_q <= s1_q & ~s2_q;
      fall_q <= ~s1_q & s2_q;
    end
  end

  assign q_o    = s2_q;
  assign rise_o = rise_q;
  assign fall_o = fall_q;
endmodule

// File: rtl/ws2812_rx.sv
// WS2812 receiver: measures high pulses, assembles MSB-first 24-bit words, flags the latch gap.
module ws2812_rx import ws2812_pkg::*; #(
  parameter int NUM_LEDS     = 8,
  parameter int CLK_MHZ      = 12,
  parameter int T_BIT_THRESH = (CLK_MHZ * T_THRESH_NS) / 1000,
  parameter int T_HIGH_MAX   = CLK_MHZ * 5,
  parameter int T_RESET_DET  = CLK_MHZ * 50,
  localparam int IW = $clog2(NUM_LEDS + 1)
) (
  input  logic          clk,
  input  logic          reset,
  input  logic          din,
  output logic [23:0]   rgb_data,
  output logic          rgb_valid,
  output logic [IW-1:0] led_index,
  output logic          frame_done,
  output logic [IW-1:0] led_count,
  output logic          error
);
  localparam int LW = $clog2(T_RESET_DET + 1);
  localparam int HW = $clog2(T_HIGH_MAX + 1);
  localparam logic [LW-1:0] LO_DET = LW'(T_RESET_DET);
  localparam logic [HW-1:0] HI_MAX = HW'(T_HIGH_MAX);
  localparam logic [HW-1:0] HI_THR = HW'(T_BIT_THRESH);
  localparam logic [IW-1:0] N_MAX  = IW'(NUM_LEDS);

  logic din_s, rise, fall;

  ws2812_sync u_sync (
    .clk    (clk),
    .reset  (reset),
    .d_i    (din),
    .q_o    (din_s),
    .rise_o (rise),
    .fall_o (fall)
  );

  rx_state_e     state_q, state_d;
  logic [HW-1:0] high_q, high_d, high_inc;
  logic [LW-1:0] low_q, low_d, low_inc;
  logic [4:0]    bits_q, bits_d;
  logic [23:0]   shift_q, shift_d, word_w;
  logic [IW-1:0] idx_q, idx_d;
  logic [23:0]   data_q, data_d;
  logic [IW-1:0] index_q, index_d, count_q, count_d;
  logic          valid_q, valid_d, done_q, done_d, err_q, err_d;
  logic          bit_w;

  assign high_inc = (high_q == HI_MAX) ? high_q : high_q + 1'b1;
  assign low_inc  = (low_q == LO_DET) ? low_q : low_q + 1'b1;
  assign bit_w    = (high_q >= HI_THR);
  assign word_w   = {shift_q[22:0], bit_w};

  always_ff @(posedge clk) begin
    if (reset) begin
      state_q <= ST_SYNC;
      high_q  <= '0;
      low_q   <= '0;
      bits_q  <= '0;
      shift_q <= '0;
      idx_q   <= '0;
      data_q  <= '0;
      index_q <= '0;
      count_q <= '0;
      valid_q <= 1'b0;
      done_q  <= 1'b0;
      err_q   <= 1'b0;
    end else begin
      state_q <= state_d;
      high_q  <= high_d;
      low_q   <= low_d;
      bits_q  <= bits_d;
      shift_q <= shift_d;
      idx_q   <= idx_d;
      data_q  <= data_d;
      index_q <= index_d;
      count_q <= count_d;
      valid_q <= valid_d;
      done_q  <= done_d;
      err_q   <= err_d;
    end
  end

  always_comb begin
    state_d = state_q;
    high_d  = high_q;
    low_d   = low_q;
    bits_d  = bits_q;
    shift_d = shift_q;
    idx_d   = idx_q;
    data_d  = data_q;
    index_d = index_q;
    count_d = count_q;
    valid_d = 1'b0;
    done_d  = 1'b0;
    err_d   = 1'b0;
    case (state_q)
      // Wait for a full latch gap so decoding never starts mid-word.
      ST_SYNC: begin
        if (din_s) low_d = '0;
        else begin
          low_d = low_inc;
          if (low_inc == LO_DET) begin
            state_d = ST_IDLE;
            low_d   = '0;
          end
        end
      end
      ST_IDLE: begin
        if (rise) begin
          state_d = ST_HIGH;
          high_d  = HW'(1);
        end
      end
      ST_HIGH: begin
        if (fall) begin
          shift_d = word_w;
          low_d   = LW'(1);
          state_d = ST_LOW;
          if (bits_q == 5'd23) begin
            bits_d = '0;
            if (idx_q < N_MAX) begin
              data_d  = word_w;
              valid_d = 1'b1;
              index_d = idx_q;
              idx_d   = idx_q + 1'b1;
            end else err_d = 1'b1;
          end else bits_d = bits_q + 1'b1;
        end else begin
          high_d = high_inc;
          if (high_inc == HI_MAX) begin
            err_d   = 1'b1;
            shift_d = '0;
            bits_d  = '0;
            idx_d   = '0;
            low_d   = '0;
            state_d = ST_SYNC;
          end
        end
      end
      ST_LOW: begin
        if (rise) begin
          state_d = ST_HIGH;
          high_d  = HW'(1);
        end else begin
          low_d = low_inc;
          if (low_inc == LO_DET) begin
            state_d = ST_IDLE;
            done_d  = 1'b1;
            count_d = idx_q;
            err_d   = (bits_q != '0);
            idx_d   = '0;
            bits_d  = '0;
            shift_d = '0;
            low_d   = '0;
          end
        end
      end
      default: state_d = ST_SYNC;
    endcase
  end

  assign rgb_data   = data_q;
  assign rgb_valid  = valid_q;
  assign led_index  = index_q;
  assign frame_done = done_q;
  assign led_count  = count_q;
  assign error      = err_q;
endmodule
